lbdr_route_unit: RTL and testbench

Parametrised successor to the minimal LBDR routing logic. It computes the output port for each packet from its HEADER flit using configurable routing and connectivity bits, and holds that port for the packet's BODY and TAIL flits. Compared with the minimal block it adds:
- a packet-tracking state machine;
- a runtime configuration port;
- unreachable-destination detection with packet drop;
- single-port selection under forks;
- optional derouting.

It sits between an input-buffer FIFO and the switch allocator in each router input channel.

---
 rtl/lbdr_route_unit.sv | 162 ++++++++++++++++
 tb/tb_lbdr_route_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lbdr_route_unit.sv
// lbdr_route_unit: LBDR route computation with packet tracking, runtime config and drop handling
//
// Sits between an input-buffer FIFO and the switch allocator. A HEADER flit is
// routed with the current Rxy/Cx/cur_addr registers; the chosen one-hot port is
// held for the BODY and TAIL flits of that packet. Unroutable headers are
// dropped together with the rest of their packet.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        asynchronous active-low reset
//   flit_vld   flit present at FIFO head
//   flit_id    flit type (`HEADER / `BODY / `TAIL)
//   dst_addr   destination {y, x}, sampled on an accepted HEADER
//   cfg_we     configuration write strobe (honoured only in IDLE)
//   cfg_rxy    routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cfg_cx     connectivity bits {Cs,Cw,Ce,Cn}
//   cfg_addr   this router's address {y, x}
//   cfg_dr     deroute ports, 2 bits per direction {S,W,E,N} (LBDR_DEROUTE_EN only)
//   port_sel   one-hot output port {L,S,W,E,N}
//   port_vld   port_sel valid for the current packet
//   drop       pulse: header unroutable, packet discarded
//   hdr_abort  pulse: HEADER arrived mid-packet
//   cfg_err    pulse: cfg_we ignored outside IDLE
//
// Optional feature macro: LBDR_DEROUTE_EN (adds cfg_dr and derouting).

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_route_unit #(
    parameter int         COORD_W  = 2,
    parameter int         RST_ADDR = 5,
    parameter logic [7:0] RST_RXY  = 8'd60,
    parameter logic [3:0] RST_CX   = 4'd15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flit_vld,
    input  logic [2:0]           flit_id,
    input  logic [2*COORD_W-1:0] dst_addr,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_rxy,
    input  logic [3:0]           cfg_cx,
    input  logic [2*COORD_W-1:0] cfg_addr,
`ifdef LBDR_DEROUTE_EN
    input  logic [7:0]           cfg_dr,
`endif
    output logic [4:0]           port_sel,
    output logic                 port_vld,
    output logic                 drop,
    output logic                 hdr_abort,
    output logic                 cfg_err
);
    localparam int AW = 2 * COORD_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_e;

    state_e          state_q, state_d;
    logic [4:0]      sel_q, sel_d;
    logic            drop_q, drop_d, abort_q, abort_d, err_q, err_d;
    logic [7:0]      rxy_q, rxy_d;
    logic [3:0]      cx_q, cx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      dr_q;
    logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
    logic            n1, s1, e1, w1, rn, re, rw, rs, rl, hdr, tail, cfg_wr;
    logic [4:0]      route, dr_sel;

    assign {y_cur, x_cur} = addr_q;
    assign {y_dst, x_dst} = dst_addr;
    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign rn = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
    assign re = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
    assign rw = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
    assign rs = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];
    assign rl = ~(n1 | s1 | e1 | w1);

`ifdef LBDR_DEROUTE_EN
    logic [1:0] dr_code;
    // Only reached when no raw request fired but some direction bit is set
    assign dr_code = n1 ? dr_q[1:0] : e1 ? dr_q[3:2] : w1 ? dr_q[5:4] : dr_q[7:6];
    assign dr_sel  = cx_q[dr_code] ? (5'b00001 << dr_code) : 5'b00000;
`else
    assign dr_sel  = 5'b00000;
`endif

    // Fixed priority N>E>W>S keeps port_sel one-hot under forks
    assign route = rn ? 5'b00001 : re ? 5'b00010 : rw ? 5'b00100 :
                   rs ? 5'b01000 : rl ? 5'b10000 : dr_sel;

    assign hdr    = flit_vld && (flit_id == `HEADER);
    assign tail   = flit_vld && (flit_id == `TAIL);
    assign cfg_wr = cfg_we && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        drop_d  = 1'b0;
        abort_d = 1'b0;
        err_d   = cfg_we && (state_q != IDLE);
        rxy_d   = cfg_wr ? cfg_rxy  : rxy_q;
        cx_d    = cfg_wr ? cfg_cx   : cx_q;
        addr_d  = cfg_wr ? cfg_addr : addr_q;
        if (hdr) begin
            abort_d = state_q != IDLE;
            sel_d   = route;
            drop_d  = ~|route;
            state_d = |route ? ACTIVE : DROP;
        end else if (tail && state_q != IDLE) begin
            state_d = IDLE;
            sel_d   = 5'b00000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            drop_q  <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            rxy_q   <= RST_RXY;
            cx_q    <= RST_CX;
            addr_q  <= AW'(RST_ADDR);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            rxy_q   <= rxy_d;
            cx_q    <= cx_d;
            addr_q  <= addr_d;
        end
    end

`ifdef LBDR_DEROUTE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dr_q <= '0;
        else if (cfg_wr) dr_q <= cfg_dr;
    end
`else
    assign dr_q = '0;
`endif

    assign port_sel  = sel_q;
    assign port_vld  = state_q == ACTIVE;
    assign drop      = drop_q;
    assign hdr_abort = abort_q;
    assign cfg_err   = err_q;
endmodule

// File: tb/tb_lbdr_route_unit.sv
// tb_lbdr_route_unit: directed + random check of lbdr_route_unit against a behavioural model

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_lbdr_route_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flit_vld = 1'b0;
    logic [2:0] flit_id = 3'b000;
    logic [3:0] dst_addr = 4'd0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_rxy = 8'd0;
    logic [3:0] cfg_cx = 4'd0;
    logic [3:0] cfg_addr = 4'd0;
    logic [7:0] cfg_dr = 8'd0;
    logic [4:0] port_sel;
    logic       port_vld, drop, hdr_abort, cfg_err;

    int vectors = 0;
    int errors  = 0;

    // Model state: 0 = idle, 1 = forwarding a packet, 2 = discarding a packet
    int         m_state;
    logic [4:0] m_sel;
    logic       m_drop, m_abort, m_err;
    logic [7:0] m_rxy, m_dr;
    logic [3:0] m_cx, m_addr;

    always #5 clk = ~clk;

    lbdr_route_unit dut (
        .clk(clk), .rst(rst), .flit_vld(flit_vld), .flit_id(flit_id), .dst_addr(dst_addr),
        .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_addr(cfg_addr),
`ifdef LBDR_DEROUTE_EN
        .cfg_dr(cfg_dr),
`endif
        .port_sel(port_sel), .port_vld(port_vld), .drop(drop),
        .hdr_abort(hdr_abort), .cfg_err(cfg_err)
    );

    // Direction index 0=N 1=E 2=W 3=S; a direction may be taken alone, or with
    // one perpendicular component when the matching Rxy turn bit is set.
    function automatic logic [4:0] ref_route(input logic [7:0] rxy, input logic [3:0] cx,
                                             input logic [3:0] addr, input logic [3:0] dst,
                                             input logic [7:0] dr);
        int xc, yc, xd, yd, p0, p1, code;
        bit dir[4];
        int perp[4][2] = '{'{1, 2}, '{0, 3}, '{0, 3}, '{1, 2}};
        int rb[4][2]   = '{'{0, 1}, '{2, 3}, '{4, 5}, '{6, 7}};
        xc = int'(addr[1:0]); yc = int'(addr[3:2]);
        xd = int'(dst[1:0]);  yd = int'(dst[3:2]);
        dir[0] = yd < yc; dir[1] = xd > xc; dir[2] = xd < xc; dir[3] = yd > yc;
        for (int d = 0; d < 4; d++) begin
            p0 = perp[d][0]; p1 = perp[d][1];
            if (dir[d] && cx[d] && ((!dir[p0] && !dir[p1]) || (dir[p0] && rxy[rb[d][0]]) ||
                                    (dir[p1] && rxy[rb[d][1]])))
                return 5'(1 << d);
        end
        if (!(dir[0] || dir[1] || dir[2] || dir[3])) return 5'b10000;
`ifdef LBDR_DEROUTE_EN
        for (int d = 0; d < 4; d++)
            if (dir[d]) begin
                code = int'(dr[2*d +: 2]);
                return cx[code] ? 5'(1 << code) : 5'b00000;
            end
`endif
        code = int'(dr[0]);
        return 5'b00000;
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 5'd0; m_drop = 1'b0; m_abort = 1'b0; m_err = 1'b0;
        m_rxy = 8'd60; m_cx = 4'd15; m_addr = 4'd5; m_dr = 8'd0;
    endtask

    task automatic check(input string tag);
        logic [8:0] obs, exp;
        obs = {port_sel, port_vld, drop, hdr_abort, cfg_err};
        exp = {m_sel, m_state == 1, m_drop, m_abort, m_err};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {sel,vld,drop,abort,err}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_sel(input string tag, input logic [4:0] exp);
        vectors++;
        assert (port_sel === exp) else begin
            errors++;
            $error("FAIL %s: observed port_sel=%b expected %b", tag, port_sel, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [2:0] id, input logic [3:0] d,
                        input logic we, input logic [7:0] rxy, input logic [3:0] cx,
                        input logic [3:0] addr, input logic [7:0] dr);
        logic [4:0] r;
        @(negedge clk);
        flit_vld = v; flit_id = id; dst_addr = d; cfg_we = we;
        cfg_rxy = rxy; cfg_cx = cx; cfg_addr = addr; cfg_dr = dr;
        @(posedge clk);
        r = ref_route(m_rxy, m_cx, m_addr, d, m_dr);
        m_drop = 1'b0; m_abort = 1'b0;
        m_err = we && m_state != 0;
        if (we && m_state == 0) begin
            m_rxy = rxy; m_cx = cx; m_addr = addr; m_dr = dr;
        end
        if (v && id == `HEADER) begin
            m_abort = m_state != 0;
            m_sel   = r;
            m_drop  = r == 5'd0;
            m_state = r != 5'd0 ? 1 : 2;
        end else if (v && id == `TAIL && m_state != 0) begin
            m_state = 0;
            m_sel   = 5'd0;
        end
        #1 check(tag);
    endtask

    task automatic flit(input string tag, input logic [2:0] id, input logic [3:0] d);
        step(tag, 1'b1, id, d, 1'b0, 8'd0, 4'd0, 4'd0, 8'd0);
    endtask

    task automatic cfg(input string tag, input logic [7:0] rxy, input logic [3:0] cx,
                       input logic [3:0] addr, input logic [7:0] dr);
        step(tag, 1'b0, `BODY, 4'd0, 1'b1, rxy, cx, addr, dr);
    endtask

    initial begin
        logic [2:0] ids[3];
        ids = '{`HEADER, `BODY, `TAIL};
        model_reset();
        #2 check("reset");
        @(negedge clk) rst = 1'b1;

        flit("hdr_south", `HEADER, 4'd13); expect_sel("south_sel", 5'b01000);
        flit("body_south", `BODY, 4'd0);   expect_sel("south_hold", 5'b01000);
        flit("tail_south", `TAIL, 4'd0);
        flit("hdr_local", `HEADER, 4'd5);  expect_sel("local_sel", 5'b10000);
        flit("tail_local", `TAIL, 4'd0);
        flit("hdr_west_b2b", `HEADER, 4'd4); expect_sel("west_sel", 5'b00100);
        flit("tail_west", `TAIL, 4'd0);

        cfg("cfg_cut_e", 8'd60, 4'b1101, 4'd5, 8'd0);
        flit("hdr_drop", `HEADER, 4'd6);
        flit("body_dropped", `BODY, 4'd0);
        flit("tail_dropped", `TAIL, 4'd0);

        cfg("cfg_fork", 8'hFF, 4'hF, 4'd5, 8'd0);
        flit("hdr_fork", `HEADER, 4'd2); expect_sel("fork_north", 5'b00001);
        cfg("cfg_busy", 8'h00, 4'h0, 4'd0, 8'd0);
        flit("hdr_abort", `HEADER, 4'd4); expect_sel("abort_west", 5'b00100);
        flit("body_pre_rst", `BODY, 4'd0);

        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1 check("async_reset");
        @(negedge clk) rst = 1'b1;
        flit("hdr_after_rst", `HEADER, 4'd6); expect_sel("east_default_cfg", 5'b00010);
        flit("tail_after_rst", `TAIL, 4'd0);

        cfg("cfg_cut_n", 8'd60, 4'b1110, 4'd5, 8'h01);
        flit("hdr_deroute", `HEADER, 4'd1);
`ifdef LBDR_DEROUTE_EN
        expect_sel("deroute_east", 5'b00010);
`endif
        flit("tail_deroute", `TAIL, 4'd0);
        cfg("cfg_cut_ne", 8'd60, 4'b1100, 4'd5, 8'h01);
        flit("hdr_deroute_cut", `HEADER, 4'd1);
        flit("tail_deroute_cut", `TAIL, 4'd0);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] id;
            id = ($urandom_range(0, 9) == 0) ? 3'($urandom) : ids[$urandom_range(0, 2)];
            step("random", $urandom_range(0, 3) != 0, id, 4'($urandom),
                 $urandom_range(0, 7) == 0, 8'($urandom),
                 $urandom_range(0, 1) ? 4'hF : 4'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
